// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 4-stage-register pipeline: forwarding selects, load-use and
// branch-compare stalls, and a counter-driven stall for a multi-cycle divide in E.
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rsD,
    input  logic [RA_W-1:0] rtD,
    input  logic [RA_W-1:0] rsE,
    input  logic [RA_W-1:0] rtE,
    input  logic [RA_W-1:0] writeregE,
    input  logic [RA_W-1:0] writeregM,
    input  logic [RA_W-1:0] writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            branchD,
    input  logic            pcsrcD,
    input  logic            jumpD,
    input  logic            div_startE,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            div_busy,
    output logic            div_done,
    output logic [1:0]      div_state
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             div_go;
    logic             lwstall, brstall, busy_raw;

    // Register $0 is hard-wired zero, so it never produces a dependency.
    function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        div_go   = 1'b0;
        case (state)
            IDLE: begin
                if (div_startE) begin
                    div_go   = 1'b1;
                    state_nx = BUSY;
                    cnt_nx   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            // The divide is still sitting in E here, so its start flag is ignored.
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        forwardAD = hit(rsD, writeregM) && regwriteM;
        forwardBD = hit(rtD, writeregM) && regwriteM;

        forwardAE = 2'b00;
        if (hit(rsE, writeregM) && regwriteM) begin
            forwardAE = 2'b10;
        end else if (hit(rsE, writeregW) && regwriteW) begin
            forwardAE = 2'b01;
        end

        forwardBE = 2'b00;
        if (hit(rtE, writeregM) && regwriteM) begin
            forwardBE = 2'b10;
        end else if (hit(rtE, writeregW) && regwriteW) begin
            forwardBE = 2'b01;
        end

        lwstall = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));
        brstall = branchD &&
                  ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                   (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
        busy_raw = div_go || (state == BUSY);

        // Every stall/flush is gated by rst so the datapath sees no spurious holds in reset.
        div_busy = busy_raw && rst;
        stallF   = (lwstall || brstall || busy_raw) && rst;
        stallD   = stallF;
        stallE   = div_busy;
        flushM   = div_busy;
        flushE   = (lwstall || brstall) && !busy_raw && rst;
        flushD   = (pcsrcD || jumpD) && !stallD && rst;
        div_done = (state == DONE);
        div_state = state;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with DIV_CYCLES=4: directed hazard,
// divide and reset scenarios followed by randomized hazard patterns.
module tb_pipeline_hazard_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int RA_W       = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic            regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic            branchD, pcsrcD, jumpD, div_startE;
    logic            stallF, stallD, stallE, flushD, flushE, flushM;
    logic            forwardAD, forwardBD, div_busy, div_done;
    logic [1:0]      forwardAE, forwardBE, div_state;
    logic [13:0]     obs;

    int checks   = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD), .div_startE(div_startE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .div_busy(div_busy), .div_done(div_done), .div_state(div_state)
    );

    assign obs = {stallF, stallD, stallE, flushD, flushE, flushM,
                  forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Expected output vector from the hazard equations; divide status is supplied by the caller.
    function automatic logic [13:0] model(input logic db, input logic dd);
        logic       lw, br, dbr, sf, fe, fd, fad, fbd;
        logic [1:0] fae, fbe;
        fad = hit(rsD, writeregM) && regwriteM;
        fbd = hit(rtD, writeregM) && regwriteM;
        fae = (hit(rsE, writeregM) && regwriteM) ? 2'b10 :
              (hit(rsE, writeregW) && regwriteW) ? 2'b01 : 2'b00;
        fbe = (hit(rtE, writeregM) && regwriteM) ? 2'b10 :
              (hit(rtE, writeregW) && regwriteW) ? 2'b01 : 2'b00;
        lw  = memtoregE && rtE != '0 && (rtE == rsD || rtE == rtD);
        br  = branchD && ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                          (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
        dbr = db && rst;
        sf  = (lw || br || dbr) && rst;
        fe  = (lw || br) && !dbr && rst;
        fd  = (pcsrcD || jumpD) && !sf && rst;
        return {sf, sf, dbr, fd, fe, dbr, fad, fbd, fae, fbe, dbr, dd};
    endfunction

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0; div_startE = 1'b0;
    endtask

    // Push the expectation for the current inputs, compare at the negedge, return after next posedge.
    task automatic step(input string tag, input logic db, input logic dd);
        exp_q.push_back(model(db, dd));
        tag_q.push_back(tag);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5; div_startE = 1'b1; pcsrcD = 1'b1;
        #2;
        check("rst_stallF", 32'(stallF), 32'd0);
        check("rst_flushD", 32'(flushD), 32'd0);
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_state", 32'(div_state), 32'd0);
        step("rst_vec", 1'b0, 1'b0);
        clear_inputs();
        rst = 1'b1;
        step("idle", 1'b0, 1'b0);

        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
        #1 check("fwdAE_M", 32'(forwardAE), 32'd2);
        step("fwd_m", 1'b0, 1'b0);
        regwriteM = 1'b0;
        #1 check("fwdAE_W", 32'(forwardAE), 32'd1);
        step("fwd_w", 1'b0, 1'b0);
        rsE = 5'd0;
        #1 check("fwdAE_r0", 32'(forwardAE), 32'd0);
        step("fwd_r0", 1'b0, 1'b0);

        clear_inputs();
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        #1;
        check("lw_stallF", 32'(stallF), 32'd1);
        check("lw_stallD", 32'(stallD), 32'd1);
        check("lw_flushE", 32'(flushE), 32'd1);
        check("lw_stallE", 32'(stallE), 32'd0);
        step("lw", 1'b0, 1'b0);
        rtE = 5'd0; rsD = 5'd0;
        #1 check("lw_r0", 32'(stallF), 32'd0);
        step("lw_r0", 1'b0, 1'b0);

        clear_inputs();
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd7; rtD = 5'd7;
        #1;
        check("br_stallD", 32'(stallD), 32'd1);
        check("br_flushE", 32'(flushE), 32'd1);
        step("br", 1'b0, 1'b0);
        regwriteE = 1'b0; writeregE = '0; writeregM = 5'd7; regwriteM = 1'b1; memtoregM = 1'b0;
        #1;
        check("br_nostall", 32'(stallD), 32'd0);
        check("br_fwdBD", 32'(forwardBD), 32'd1);
        step("br_fwd", 1'b0, 1'b0);

        // Divide with a taken branch in D during T1 and T4; div_startE stays high into DONE.
        clear_inputs();
        for (int t = 0; t < 6; t++) begin
            div_startE = (t <= 4);
            pcsrcD     = (t == 1 || t == 4);
            #1;
            if (t == 1) check("div_flushD_T1", 32'(flushD), 32'd0);
            if (t == 4) begin
                check("div_flushD_T4", 32'(flushD), 32'd1);
                check("div_done_T4", 32'(div_done), 32'd1);
                check("div_stall_T4", 32'(stallF), 32'd0);
            end
            if (t == 5) check("div_busy_T5", 32'(div_busy), 32'd0);
            step($sformatf("div_t%0d", t), t < 4, t == 4);
        end

        // Reset in the middle of a divide.
        clear_inputs();
        div_startE = 1'b1;
        step("abort_t0", 1'b1, 1'b0);
        step("abort_t1", 1'b1, 1'b0);
        check("abort_busy_T2", 32'(div_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_busy0", 32'(div_busy), 32'd0);
        check("abort_stallF0", 32'(stallF), 32'd0);
        check("abort_flushM0", 32'(flushM), 32'd0);
        check("abort_state", 32'(div_state), 32'd0);
        step("abort_rst", 1'b0, 1'b0);
        rst = 1'b1;
        div_startE = 1'b0;
        for (int t = 0; t < 5; t++) step($sformatf("after_abort%0d", t), 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            div_startE = (t <= 4);
            step($sformatf("restart_t%0d", t), t < 4, t == 4);
        end

        clear_inputs();
        for (int i = 0; i < 40; i++) begin
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
            memtoregM = 1'($urandom_range(0, 1)); branchD = 1'($urandom_range(0, 1));
            pcsrcD = 1'($urandom_range(0, 1)); jumpD = 1'($urandom_range(0, 1));
            step($sformatf("rand%0d", i), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
